c5_mem_arbiter: RTL

- Shares one single-ported memory bus between the instruction-fetch port and the load/store data port of the c5 pipeline core.
- Arbitrates between the two requesters and sequences each transaction through a small FSM.
- Holds the losing requester in stall and returns read data with a one-cycle response phase.
- Aborts hung transactions with a timeout counter.

---
 rtl/c5_mem_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/c5_mem_arbiter.sv
// c5_mem_arbiter
//   Shares one single-ported memory bus between the instruction-fetch port and
//   the load/store data port. A three-state FSM (IDLE -> BUS -> RESP) sequences
//   each transaction: the winner is registered onto the bus in IDLE, the bus
//   cycle runs until ack or timeout in BUS, and the owner's stall drops for one
//   cycle in RESP. Ties are resolved round-robin; data wins the first tie.
//
// Ports
//   I_clk, I_rst                 clock (rising edge), synchronous active-high reset
//   I_i_adr, I_i_stb             instruction fetch request
//   O_i_dat, O_i_stall           fetched instruction / instruction port wait
//   I_d_adr, I_d_stb, I_d_we,    data request (address, strobe, write enable,
//   I_d_sel, I_d_dat             byte selects, write data)
//   O_d_dat, O_d_stall           read data / data port wait
//   O_m_adr, O_m_stb, O_m_we,    memory bus request (registered)
//   O_m_sel, O_m_dat
//   I_m_dat, I_m_ack             memory read data / single-cycle acknowledge
//   O_err                        one-cycle pulse when a transaction times out
module c5_mem_arbiter #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_i_adr,
    input  logic        I_i_stb,
    output logic [31:0] O_i_dat,
    output logic        O_i_stall,
    input  logic [31:0] I_d_adr,
    input  logic        I_d_stb,
    input  logic        I_d_we,
    input  logic [3:0]  I_d_sel,
    input  logic [31:0] I_d_dat,
    output logic [31:0] O_d_dat,
    output logic        O_d_stall,
    output logic [31:0] O_m_adr,
    output logic        O_m_stb,
    output logic        O_m_we,
    output logic [3:0]  O_m_sel,
    output logic [31:0] O_m_dat,
    input  logic [31:0] I_m_dat,
    input  logic        I_m_ack,
    output logic        O_err
);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;
    typedef enum logic {OwnInstr, OwnData} owner_e;

    localparam bit         TimeoutEn   = (TIMEOUT != 0);
    localparam logic [7:0] TimeoutLast = TimeoutEn ? 8'(TIMEOUT - 1) : 8'd0;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] m_adr_q, m_adr_d;
    logic [31:0] m_dat_q, m_dat_d;
    logic [31:0] i_dat_q, i_dat_d;
    logic [31:0] d_dat_q, d_dat_d;
    logic [3:0]  m_sel_q, m_sel_d;
    logic        m_stb_q, m_stb_d;
    logic        m_we_q, m_we_d;
    logic        err_q, err_d;

    logic        req_any;
    owner_e      winner;
    logic        timeout_hit;

    assign req_any = I_i_stb | I_d_stb;

    // On a tie, grant whichever port did not win the previous arbitration.
    assign winner = (I_i_stb & I_d_stb) ?
                    ((last_grant_q == OwnInstr) ? OwnData : OwnInstr) :
                    (I_d_stb ? OwnData : OwnInstr);

    // Counter equals the number of BUS cycles already spent without ack.
    assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

    // State register
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_any) state_d = StBus;
            StBus:   if (I_m_ack || timeout_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_adr_d      = m_adr_q;
        m_dat_d      = m_dat_q;
        m_sel_d      = m_sel_q;
        m_we_d       = m_we_q;
        m_stb_d      = m_stb_q;
        i_dat_d      = i_dat_q;
        d_dat_d      = d_dat_q;
        err_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = '0;
                    m_stb_d      = 1'b1;
                    if (winner == OwnData) begin
                        m_adr_d = I_d_adr;
                        m_we_d  = I_d_we;
                        m_sel_d = I_d_sel;
                        m_dat_d = I_d_dat;
                    end else begin
                        m_adr_d = I_i_adr;
                        m_we_d  = 1'b0;
                        m_sel_d = 4'hF;
                        m_dat_d = '0;
                    end
                end
            end
            StBus: begin
                // Ack takes priority over a coincident timeout.
                if (I_m_ack) begin
                    m_stb_d = 1'b0;
                    if (owner_q == OwnData) d_dat_d = I_m_dat;
                    else                    i_dat_d = I_m_dat;
                end else if (timeout_hit) begin
                    m_stb_d = 1'b0;
                    err_d   = 1'b1;
                    if (owner_q == OwnData) d_dat_d = '0;
                    else                    i_dat_d = NOP_INSTR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: ;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            owner_q      <= OwnInstr;
            last_grant_q <= OwnInstr;
            cnt_q        <= '0;
            m_adr_q      <= '0;
            m_dat_q      <= '0;
            m_sel_q      <= 4'h0;
            m_we_q       <= 1'b0;
            m_stb_q      <= 1'b0;
            i_dat_q      <= '0;
            d_dat_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_adr_q      <= m_adr_d;
            m_dat_q      <= m_dat_d;
            m_sel_q      <= m_sel_d;
            m_we_q       <= m_we_d;
            m_stb_q      <= m_stb_d;
            i_dat_q      <= i_dat_d;
            d_dat_q      <= d_dat_d;
            err_q        <= err_d;
        end
    end

    assign O_i_stall = I_i_stb & ~((state_q == StResp) & (owner_q == OwnInstr));
    assign O_d_stall = I_d_stb & ~((state_q == StResp) & (owner_q == OwnData));

    assign O_m_adr = m_adr_q;
    assign O_m_stb = m_stb_q;
    assign O_m_we  = m_we_q;
    assign O_m_sel = m_sel_q;
    assign O_m_dat = m_dat_q;
    assign O_i_dat = i_dat_q;
    assign O_d_dat = d_dat_q;
    assign O_err   = err_q;

endmodule
